// File: rtl/sub_a_pipe_if.sv
// Stream bundle for sub_a_pipe: operand/mode input side and result output side.
// slave = the pipe itself, master = the upstream/downstream environment.
interface sub_a_pipe_if #(
  parameter int LANES = 4,
  parameter int WIDTH = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               mode;
  logic [LANES*WIDTH-1:0]   in_a;
  logic [LANES*WIDTH-1:0]   in_b;
  logic [LANES*WIDTH-1:0]   in_c;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*WIDTH-1:0]   out_res;
  logic [LANES-1:0]         out_carry;

  modport master (
    output in_valid, mode, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_res, out_carry
  );

  modport slave (
    input  in_valid, mode, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_res, out_carry
  );
endinterface

// File: rtl/sub_a_pipe.sv
// Per-lane add/xor/or datapath in an elastic DEPTH-stage pipeline; result DEPTH cycles after accept.
// Bubbles collapse, so DEPTH entries fit; in_ready drops only when every stage is full and out_ready=0.
module sub_a_pipe #(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              zero_tied,
  sub_a_pipe_if.slave       bus,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              cnt_wrap,
  output logic              carry_seen
);
  localparam int DW = LANES * WIDTH;

  logic [DEPTH-1:0] r_vld;
  logic [DW-1:0]    r_res [DEPTH];
  logic [LANES-1:0] r_car [DEPTH];

  logic [DEPTH-1:0] w_open;
  logic             w_in_rdy;
  logic             w_in_fire;
  logic             w_out_fire;
  logic [DW-1:0]    w_res;
  logic [LANES-1:0] w_car;
  logic [WIDTH:0]   w_sum;

  // A stage can take a new entry if it, or any stage after it, is empty, or the tail drains.
  always_comb begin
    w_open = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_open[k] = bus.out_ready || (|((~r_vld) >> k));
    end
  end

  assign w_in_rdy   = !zero_tied && w_open[0];
  assign w_in_fire  = bus.in_valid && w_in_rdy;
  assign w_out_fire = r_vld[DEPTH-1] && bus.out_ready;

  assign bus.in_ready  = w_in_rdy;
  assign bus.out_valid = r_vld[DEPTH-1];
  assign bus.out_res   = r_res[DEPTH-1];
  assign bus.out_carry = r_car[DEPTH-1];

  always_comb begin
    w_res = '0;
    w_car = '0;
    w_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      w_sum = {1'b0, bus.in_a[l*WIDTH +: WIDTH]} + {1'b0, bus.in_b[l*WIDTH +: WIDTH]};
      case (bus.mode)
        2'd0: begin
          w_res[l*WIDTH +: WIDTH] = w_sum[WIDTH-1:0];
          w_car[l]                = w_sum[WIDTH];
        end
        2'd1:    w_res[l*WIDTH +: WIDTH] = bus.in_b[l*WIDTH +: WIDTH] ^ bus.in_c[l*WIDTH +: WIDTH];
        2'd2:    w_res[l*WIDTH +: WIDTH] = bus.in_a[l*WIDTH +: WIDTH] ^ bus.in_c[l*WIDTH +: WIDTH];
        default: w_res[l*WIDTH +: WIDTH] = bus.in_a[l*WIDTH +: WIDTH] | bus.in_b[l*WIDTH +: WIDTH]
                                         | bus.in_c[l*WIDTH +: WIDTH];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld      <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_res[k] <= '0;
        r_car[k] <= '0;
      end
      xfer_cnt   <= '0;
      cnt_wrap   <= 1'b0;
      carry_seen <= 1'b0;
    end else if (zero_tied) begin
      // Flush wins over any handshake on the same edge; data registers are left as-is.
      r_vld      <= '0;
      xfer_cnt   <= '0;
      cnt_wrap   <= 1'b0;
      carry_seen <= 1'b0;
    end else begin
      if (w_open[0]) begin
        r_vld[0] <= w_in_fire;
        if (w_in_fire) begin
          r_res[0] <= w_res;
          r_car[0] <= w_car;
        end
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (w_open[k]) begin
          r_vld[k] <= r_vld[k-1];
          if (r_vld[k-1]) begin
            r_res[k] <= r_res[k-1];
            r_car[k] <= r_car[k-1];
          end
        end
      end
      if (w_out_fire) begin
        xfer_cnt <= xfer_cnt + CNT_W'(1);
        if (&xfer_cnt) begin
          cnt_wrap <= 1'b1;
        end
        if (|r_car[DEPTH-1]) begin
          carry_seen <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/sub_a_pipe.md
Name: sub_a_pipe

Overview:
- Parametrised, pipelined successor to the per-bit combinational sub_a datapath.
- Processes LANES independent WIDTH-bit lanes per transaction. Mode selects add, the two XOR combinations or a 3-input OR.
- Valid/ready handshake on both sides; elastic pipeline of DEPTH stages.
- Keeps transfer statistics: wrap counter plus sticky carry and wrap flags. Sits between the input staging logic and the sub_sub_a consumers.

Parameters:
LANES, 4, number of independent lanes
WIDTH, 8, bits per lane
DEPTH, 2, pipeline stages (legal 1..4); also entry capacity
CNT_W, 16, width of transfer counter

Ports:
clk  input  1  single clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
zero_tied  input  1  synchronous flush/clear, active-high
in_valid  input  1  input transaction valid
in_ready  output  1  block can accept input this cycle
mode  input  2  operation select, sampled with accepted transaction
in_a  input  LANES*WIDTH  operand a, lane i at [i*WIDTH +: WIDTH]
in_b  input  LANES*WIDTH  operand b
in_c  input  LANES*WIDTH  operand c
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_res  output  LANES*WIDTH  per-lane result
out_carry  output  LANES  per-lane carry (mode 0 only)
xfer_cnt  output  CNT_W  count of output handshakes
cnt_wrap  output  1  sticky: xfer_cnt wrapped
carry_seen  output  1  sticky: any transferred out_carry bit was 1

Behaviour:
- Reset (reset_n=0, asynchronous): all stage valid bits=0, out_valid=0, out_res=0, out_carry=0, xfer_cnt=0, cnt_wrap=0, carry_seen=0. in_ready=1 from the first cycle after reset_n deasserts (zero_tied low).
- Accept: in_valid && in_ready at a rising edge. Compute happens at stage-0 capture, per lane:
  - mode 0: {carry,res} = a+b, WIDTH+1-bit sum.
  - mode 1: res = b^c.
  - mode 2: res = a^c.
  - mode 3: res = a|b|c.
  - carry=0 in modes 1-3.
- Pipeline: DEPTH registered stages, each holding one entry {res,carry}. Stage k loads from stage k-1 when stage k is empty or is itself advancing. Last stage drives out_res/out_carry/out_valid.
- Latency: out_valid rises exactly DEPTH cycles after the accept edge when the pipeline is otherwise empty and out_ready=1.
- Throughput: one transaction per cycle with out_ready held high.
- in_ready = !zero_tied && (stage 0 empty || stage 0 advances). A combinational path out_ready->in_ready is permitted.
- Backpressure: while out_valid && !out_ready, out_res/out_carry are held stable. The pipeline compresses bubbles, so capacity is DEPTH entries. When all stages are full and out_ready=0, in_ready=0.
- Ordering: strict FIFO order; no loss or duplication under any valid/ready pattern.
- Handshake rules:
  - Upstream must hold in_* stable while in_valid && !in_ready.
  - out_valid never drops without a handshake, except on zero_tied or reset.
- Output handshake (out_valid && out_ready):
  - xfer_cnt increments modulo 2^CNT_W.
  - On the increment from all-ones to 0, cnt_wrap is set (sticky).
  - carry_seen |= |out_carry.
- zero_tied=1 at an edge:
  - All stage valid bits cleared; in-flight entries are discarded; out_valid=0 next cycle.
  - xfer_cnt, cnt_wrap, carry_seen cleared.
  - Data registers need not be cleared.
  - in_ready=0 while zero_tied=1.
  - zero_tied takes priority over a simultaneous input or output handshake: that handshake is not counted and its data is not retained.
- reset_n asserted mid-operation: immediate clear as in reset, regardless of handshake state.
- Lanes are fully independent: no carry propagates between lanes.

Test Plan:
- Reset: assert reset_n=0 mid-stream with 2 entries in flight -> out_valid=0, xfer_cnt=0, flags=0 immediately; in_ready=1 one cycle after release.
- Mode 0, LANES=4, WIDTH=8, DEPTH=2: accept in_a=0x01_7F_FF_F0, in_b=0x01_01_01_20 -> 2 cycles later out_res=0x02_80_00_10, out_carry=4'b0011; after handshake carry_seen=1, xfer_cnt=1.
- Modes 1/2/3: a=0x0F0F0F0F, b=0x00FF00FF, c=0x33333333 -> out_res = 0x33CC33CC (mode 1), 0x3C3C3C3C (mode 2), 0x3FFF3FFF (mode 3); out_carry=0.
- Streaming: 8 back-to-back accepts with distinct data, out_ready=1 -> 8 results on consecutive cycles starting cycle 2, in order; xfer_cnt=8.
- Backpressure: out_ready=0 while streaming -> exactly 2 accepts then in_ready=0; out_res stable. Toggle out_ready 1/0 randomly -> every input appears once, in order.
- zero_tied: 1-cycle pulse with 2 entries in flight and xfer_cnt=5 -> out_valid=0, xfer_cnt=0 next cycle; subsequent accept yields only new data. With CNT_W=4, 16 transfers -> xfer_cnt=0, cnt_wrap=1.
